// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: decode fields in, datapath enables and selects out
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_bit5;
  logic       ALU_zero;
  logic       PC_write;
  logic       addr_src;
  logic       IR_write;
  logic       memory_write;
  logic       register_write;
  logic [1:0] result_src;
  logic [1:0] ALU_src_A;
  logic [1:0] ALU_src_B;
  logic [1:0] imm_src;
  logic [2:0] ALU_ctrl;
  logic [3:0] state;
  logic       instr_retire;
  modport master (
    input  opcode, funct3, funct7_bit5, ALU_zero,
    output PC_write, addr_src, IR_write, memory_write, register_write,
           result_src, ALU_src_A, ALU_src_B, imm_src, ALU_ctrl, state, instr_retire
  );
  modport slave (
    output opcode, funct3, funct7_bit5, ALU_zero,
    input  PC_write, addr_src, IR_write, memory_write, register_write,
           result_src, ALU_src_A, ALU_src_B, imm_src, ALU_ctrl, state, instr_retire
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencing RV32I instructions through the shared multi-cycle datapath
module multicycle_controller (
  input logic clk,
  input logic rst_n,
  multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
    MEMWB = 4'd4, MEMWRITE = 4'd5, EXECUTER = 4'd6, ALUWB = 4'd7,
    EXECUTEI = 4'd8, JAL = 4'd9, BRANCH = 4'd10, JALRADR = 4'd11
  } state_t;
  state_t state_q, state_d;
  logic pc_write, ir_write, mem_write, reg_write, addr_src, retire;
  logic [1:0] result_src, src_a, src_b;
  logic [2:0] alu_ctrl, alu_fn;
  logic taken;
  assign taken = bus.ALU_zero ^ bus.funct3[0];
  assign alu_fn = bus.funct3 == 3'b000 ? ((bus.funct7_bit5 & bus.opcode[5]) ? 3'b001 : 3'b000) :
                  bus.funct3 == 3'b010 ? 3'b101 :
                  bus.funct3 == 3'b110 ? 3'b011 :
                  bus.funct3 == 3'b111 ? 3'b010 : 3'b000;
  // state register; reset returns to FETCH immediately
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= FETCH;
    else state_q <= state_d;
  // next-state and per-state control outputs
  always_comb begin
    state_d = FETCH;
    pc_write = 1'b0;
    ir_write = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    addr_src = 1'b0;
    retire = 1'b0;
    result_src = 2'b00;
    src_a = 2'b00;
    src_b = 2'b00;
    alu_ctrl = 3'b000;
    case (state_q)
      FETCH: begin
        state_d = DECODE;
        ir_write = 1'b1;
        src_b = 2'b10;
        result_src = 2'b10;
        pc_write = 1'b1;
      end
      DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
        state_d = (bus.opcode == 7'b0000011 || bus.opcode == 7'b0100011) ? MEMADR :
                  bus.opcode == 7'b0110011 ? EXECUTER :
                  bus.opcode == 7'b0010011 ? EXECUTEI :
                  bus.opcode == 7'b1101111 ? JAL :
                  bus.opcode == 7'b1100111 ? JALRADR :
                  bus.opcode == 7'b1100011 ? BRANCH : FETCH;
      end
      MEMADR: begin
        src_a = 2'b10;
        src_b = 2'b01;
        state_d = bus.opcode[5] ? MEMWRITE : MEMREAD;
      end
      JALRADR: begin
        src_a = 2'b10;
        src_b = 2'b01;
        state_d = JAL;
      end
      MEMREAD: begin
        addr_src = 1'b1;
        state_d = MEMWB;
      end
      MEMWRITE: begin
        addr_src = 1'b1;
        mem_write = 1'b1;
        retire = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write = 1'b1;
        retire = 1'b1;
      end
      EXECUTER: begin
        src_a = 2'b10;
        alu_ctrl = alu_fn;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        src_a = 2'b10;
        src_b = 2'b01;
        alu_ctrl = alu_fn;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        retire = 1'b1;
      end
      JAL: begin
        src_a = 2'b01;
        src_b = 2'b10;
        pc_write = 1'b1;
        state_d = ALUWB;
      end
      BRANCH: begin
        src_a = 2'b10;
        alu_ctrl = 3'b001;
        retire = 1'b1;
        pc_write = taken;
      end
      default: state_d = FETCH;
    endcase
  end
  assign bus.PC_write = rst_n & pc_write;
  assign bus.IR_write = rst_n & ir_write;
  assign bus.memory_write = rst_n & mem_write;
  assign bus.register_write = rst_n & reg_write;
  assign bus.addr_src = addr_src;
  assign bus.instr_retire = retire;
  assign bus.result_src = result_src;
  assign bus.ALU_src_A = src_a;
  assign bus.ALU_src_B = src_b;
  assign bus.ALU_ctrl = alu_ctrl;
  assign bus.state = state_q;
  assign bus.imm_src = bus.opcode == 7'b0100011 ? 2'b01 :
                       bus.opcode == 7'b1100011 ? 2'b10 :
                       bus.opcode == 7'b1101111 ? 2'b11 : 2'b00;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench comparing every cycle against an instruction-level model
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int fails = 0;
  logic [20:0] q[$];
  logic [20:0] act;
  always #5 clk = ~clk;
  multicycle_controller_if bus();
  multicycle_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  assign act = {bus.state, bus.PC_write, bus.addr_src, bus.IR_write, bus.memory_write,
                bus.register_write, bus.result_src, bus.ALU_src_A, bus.ALU_src_B,
                bus.imm_src, bus.ALU_ctrl, bus.instr_retire};
  function automatic logic [2:0] alu_op(logic [2:0] f3, logic sub_ok);
    return f3 == 3'd0 ? (sub_ok ? 3'd1 : 3'd0) : f3 == 3'd2 ? 3'd5 :
           f3 == 3'd6 ? 3'd3 : f3 == 3'd7 ? 3'd2 : 3'd0;
  endfunction
  // expected output word for one cycle of an instruction, given which step it is in
  function automatic logic [20:0] model(int st, logic [6:0] op, logic [2:0] f3, logic f7, logic z);
    logic pcw, as, irw, mw, rw, ret;
    logic [1:0] rs, a, b, imm;
    logic [2:0] alu;
    logic [3:0] s;
    pcw = 0; as = 0; irw = 0; mw = 0; rw = 0; ret = 0;
    rs = 0; a = 0; b = 0; alu = 0;
    s = st[3:0];
    imm = op == 7'b0100011 ? 2'b01 : op == 7'b1100011 ? 2'b10 : op == 7'b1101111 ? 2'b11 : 2'b00;
    case (st)
      0: begin irw = 1; b = 2; rs = 2; pcw = 1; end
      1: begin a = 1; b = 1; end
      2, 11: begin a = 2; b = 1; end
      3: as = 1;
      4: begin rs = 1; rw = 1; ret = 1; end
      5: begin as = 1; mw = 1; ret = 1; end
      6: begin a = 2; alu = alu_op(f3, f7); end
      7: begin rw = 1; ret = 1; end
      8: begin a = 2; b = 1; alu = alu_op(f3, 1'b0); end
      9: begin a = 1; b = 2; pcw = 1; end
      10: begin a = 2; alu = 1; ret = 1; pcw = f3[0] ? !z : z; end
      default: ;
    endcase
    return {s, pcw, as, irw, mw, rw, rs, a, b, imm, alu, ret};
  endfunction
  task automatic chk(string name, logic [20:0] got, logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, got, exp);
    end
  endtask
  // issue one instruction starting in FETCH and queue its expected cycle words
  task automatic run(logic [6:0] op, logic [2:0] f3, logic f7, logic z);
    int seq[$];
    case (op)
      7'b0000011: seq = {0, 1, 2, 3, 4};
      7'b0100011: seq = {0, 1, 2, 5};
      7'b0110011: seq = {0, 1, 6, 7};
      7'b0010011: seq = {0, 1, 8, 7};
      7'b1101111: seq = {0, 1, 9, 7};
      7'b1100111: seq = {0, 1, 11, 9, 7};
      7'b1100011: seq = {0, 1, 10};
      default: seq = {0, 1};
    endcase
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7_bit5 = f7;
    bus.ALU_zero = z;
    foreach (seq[i]) q.push_back(model(seq[i], op, f3, f7, z));
    repeat (seq.size()) @(posedge clk);
    #1;
  endtask
  // monitor: every cycle with a pending expectation is compared
  always @(negedge clk)
    if (q.size() > 0) begin
      logic [20:0] e;
      e = q.pop_front();
      checks++;
      if (act !== e) begin
        fails++;
        $display("FAIL cycle_word t=%0t actual=%h expected=%h", $time, act, e);
      end
    end
  initial begin
    logic [6:0] legal[7];
    logic [6:0] op;
    legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111, 7'b1100011};
    rst_n = 1'b0;
    bus.opcode = 7'b0000011;
    bus.funct3 = 3'b010;
    bus.funct7_bit5 = 1'b0;
    bus.ALU_zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_word", act, model(0, 7'b0000011, 3'b010, 1'b0, 1'b0) & ~21'h17000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(7'b0000011, 3'b010, 1'b0, 1'b0);
    run(7'b0100011, 3'b010, 1'b0, 1'b0);
    run(7'b0110011, 3'b000, 1'b1, 1'b0);
    run(7'b0110011, 3'b111, 1'b0, 1'b0);
    run(7'b0010011, 3'b000, 1'b1, 1'b0);
    run(7'b0010011, 3'b110, 1'b0, 1'b0);
    run(7'b0010011, 3'b010, 1'b0, 1'b0);
    run(7'b1100011, 3'b000, 1'b0, 1'b1);
    run(7'b1100011, 3'b001, 1'b0, 1'b1);
    run(7'b1100011, 3'b001, 1'b0, 1'b0);
    run(7'b1100011, 3'b110, 1'b0, 1'b0);
    run(7'b1101111, 3'b000, 1'b0, 1'b0);
    run(7'b1100111, 3'b000, 1'b0, 1'b0);
    run(7'b1111111, 3'b000, 1'b0, 1'b0);
    for (int n = 0; n < 200; n++) begin
      int k;
      k = $urandom_range(0, 7);
      if (k < 7) op = legal[k];
      else begin
        op = 7'($urandom_range(0, 127));
        while (op inside {legal}) op = 7'($urandom_range(0, 127));
      end
      run(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    bus.opcode = 7'b0100011;
    repeat (3) @(posedge clk);
    #1 chk("sw_in_memwrite", {16'd0, bus.state, bus.memory_write}, {16'd0, 4'd5, 1'b1});
    rst_n = 1'b0;
    #1 chk("abort_memwrite", {16'd0, bus.state, bus.memory_write}, {16'd0, 4'd0, 1'b0});
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("queue_drained", 21'(q.size()), 21'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state sequencer for the multi-cycle RV32I core: it steps each instruction through fetch, decode, execute, memory and writeback, so the ALU, memory port and register file are shared across cycles. It drives every datapath enable and mux select, and registers only its own state. Decode fields come from the datapath's instruction register (IR). Supported instructions: lw, sw, R-type ALU, I-type ALU, beq/bne, jal, jalr.

## Interface
- No parameters.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7_bit5  in  1  IR[30].
- ALU_zero  in  1  combinational zero flag of the current ALU result.
- PC_write  out  1  PC <= result bus.
- addr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IR_write  out  1  IR and OldPC capture memory read data and PC.
- memory_write  out  1  data memory write strobe.
- register_write  out  1  register file write of result bus into rd.
- result_src  out  2  result select: 00 = ALUOut, 01 = memory data register, 10 = live ALU result.
- ALU_src_A  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register.
- ALU_src_B  out  2  ALU B select: 00 = rs2 register, 01 = immediate, 10 = constant 4.
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALU_ctrl  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- state  out  4  current state encoding, for debug.
- instr_retire  out  1  high in the final cycle of each legal instruction.

## Operation
- State encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3
  - MEMWB = 4, MEMWRITE = 5, EXECUTER = 6, ALUWB = 7
  - EXECUTEI = 8, JAL = 9, BRANCH = 10, JALRADR = 11
  - Encodings 12–15 are unused and return to FETCH on the next clock.
- Transitions:
  - FETCH -> DECODE.
  - DECODE, by opcode:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR
    - 0110011 (R-type) -> EXECUTER
    - 0010011 (I-type ALU) -> EXECUTEI
    - 1101111 (jal) -> JAL
    - 1100111 (jalr) -> JALRADR
    - 1100011 (branch) -> BRANCH
    - any other opcode -> FETCH, silently dropped, no writes, no retire.
  - MEMADR -> MEMREAD if opcode[5] = 0, else MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECUTER, EXECUTEI -> ALUWB.
  - JALRADR -> JAL.
  - JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH -> FETCH.
- Per-state outputs. Any signal not listed is 0; ALU_ctrl is add unless noted.
  - FETCH: addr_src = 0, IR_write = 1, A = 00, B = 10, result_src = 10, PC_write = 1.
  - DECODE: A = 01, B = 01 (ALUOut <= OldPC + imm, the branch/jal target).
  - MEMADR and JALRADR: A = 10, B = 01.
  - MEMREAD: addr_src = 1.
  - MEMWRITE: addr_src = 1, memory_write = 1, instr_retire = 1.
  - MEMWB: result_src = 01, register_write = 1, instr_retire = 1.
  - EXECUTER: A = 10, B = 00, ALU_ctrl from function decode.
  - EXECUTEI: A = 10, B = 01, ALU_ctrl from function decode.
  - ALUWB: result_src = 00, register_write = 1, instr_retire = 1.
  - JAL: A = 01, B = 10, result_src = 00, PC_write = 1 (PC <= target while ALU computes OldPC + 4 into ALUOut).
  - BRANCH: A = 10, B = 00, ALU_ctrl = sub, result_src = 00, instr_retire = 1, PC_write = taken.
- Branch rule: taken = ALU_zero XOR funct3[0]; funct3 bits [2:1] are ignored.
- Function decode (EXECUTER/EXECUTEI):
  - funct3 000: sub if funct7_bit5 & opcode[5], else add.
  - funct3 010: slt. funct3 110: or. funct3 111: and.
  - any other funct3: add.
- imm_src is combinational from opcode in every state: sw -> 01, branch -> 10, jal -> 11, otherwise 00.
- jalr target is not LSB-masked; the datapath owns alignment.

## Timing
- Moore outputs, except two Mealy terms: PC_write in BRANCH (depends on ALU_zero) and ALU_ctrl in EXECUTE states (depends on funct fields).
- Cycles per instruction, FETCH through retire inclusive:
  - lw 5, jalr 5
  - sw 4, R 4, I 4, jal 4
  - branch 3
  - illegal opcode 2
- Reset:
  - rst_n low forces state = FETCH immediately (asynchronous).
  - While rst_n is low, PC_write, IR_write, register_write and memory_write are forced 0; other outputs take their FETCH values.
  - First fetch edge is the first rising clk with rst_n high.
  - Reset asserted mid-instruction aborts it with no further writes.
- instr_retire is exactly one cycle wide per legal instruction.

## Test plan
- Reset: hold rst_n = 0 across 3 clks -> state = 0, all four write enables 0. Release -> DECODE on the next edge.
- lw (opcode 0000011): state sequence 0,1,2,3,4 -> register_write = 1 with result_src = 01 only in state 4; instr_retire pulses once.
- sw then R-type sub (funct3 000, funct7_bit5 = 1): sw -> memory_write = 1 in state 5 only. sub -> ALU_ctrl = 001 in state 6, ALUWB in state 7.
- Branches: beq with ALU_zero = 1 -> PC_write = 1 in state 10. bne (funct3 001) with ALU_zero = 1 -> PC_write = 0. Both return to state 0 after 3 cycles.
- jal / jalr: jal states 0,1,9,7; jalr states 0,1,11,9,7. PC_write = 1 in state 9, register_write = 1 in state 7.
- Illegal opcode 1111111 -> states 0,1,0 with no write enables and no instr_retire. Assert rst_n = 0 during MEMWRITE -> memory_write drops to 0 within the same cycle.
